// File: rtl/troco_dispenser.sv
// Greedy change dispenser: largest coin first, one coin pulse per eject.
// Optional BCD readout of troco_pendente when TROCO_BCD_EN is defined.
module troco_dispenser #(
  parameter int unsigned D0        = 5,
  parameter int unsigned D1        = 10,
  parameter int unsigned D2        = 25,
  parameter int unsigned D3        = 50,
  parameter int unsigned EJECT_GAP = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        troco_valido,
  input  logic [7:0]  valor_troco,
  input  logic [23:0] moedas_carteira,
  output logic        moeda_ejetada,
  output logic [1:0]  tipo_moeda,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro,
  output logic [7:0]  troco_pendente,
  output logic [23:0] moedas_restantes
`ifdef TROCO_BCD_EN
  ,
  output logic [3:0]  troco_pendente_c,
  output logic [3:0]  troco_pendente_d,
  output logic [3:0]  troco_pendente_u
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    GAP,
    DONE
  } state_t;

  localparam logic [7:0] DEN [4] = '{8'(D0), 8'(D1), 8'(D2), 8'(D3)};
  localparam logic [7:0] GAP_INI =
    (EJECT_GAP > 0) ? 8'(EJECT_GAP - 1) : 8'd0;

  state_t      state;
  logic [7:0]  gap_cnt;
  logic        sel_ok;
  logic [1:0]  sel_k;
  logic [7:0]  ej_den;
  logic [23:0] rest_dec;

  // Highest slot that still has coins and fits in the pending change
  always_comb begin
    sel_ok = 1'b0;
    sel_k  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (moedas_restantes[6*k +: 6] != 6'd0 &&
          DEN[k] <= troco_pendente) begin
        sel_ok = 1'b1;
        sel_k  = 2'(k);
      end
    end
  end

  // Value and wallet update of the coin being ejected
  always_comb begin
    ej_den   = DEN[tipo_moeda];
    rest_dec = moedas_restantes -
      (24'd1 << (5'd6 * {3'd0, tipo_moeda}));
  end

  // Dispense sequencer with registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      gap_cnt          <= 8'd0;
      moeda_ejetada    <= 1'b0;
      tipo_moeda       <= 2'd0;
      ocupado          <= 1'b0;
      concluido        <= 1'b0;
      erro             <= 1'b0;
      troco_pendente   <= 8'd0;
      moedas_restantes <= 24'd0;
    end else begin
      moeda_ejetada <= 1'b0;
      concluido     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (troco_valido) begin
            troco_pendente   <= valor_troco;
            moedas_restantes <= moedas_carteira;
            erro             <= 1'b0;
            ocupado          <= 1'b1;
            state            <= SELECT;
          end
        end
        SELECT: begin
          if (troco_pendente == 8'd0) begin
            erro      <= 1'b0;
            concluido <= 1'b1;
            ocupado   <= 1'b0;
            state     <= DONE;
          end else if (sel_ok) begin
            moeda_ejetada <= 1'b1;
            tipo_moeda    <= sel_k;
            state         <= EJECT;
          end else begin
            erro      <= 1'b1;
            concluido <= 1'b1;
            ocupado   <= 1'b0;
            state     <= DONE;
          end
        end
        EJECT: begin
          troco_pendente   <= troco_pendente - ej_den;
          moedas_restantes <= rest_dec;
          if (EJECT_GAP > 0) begin
            gap_cnt <= GAP_INI;
            state   <= GAP;
          end else begin
            state <= SELECT;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) state <= SELECT;
          else gap_cnt <= gap_cnt - 8'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TROCO_BCD_EN
  // Decimal digits of the pending change, one cycle behind it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      troco_pendente_c <= 4'd0;
      troco_pendente_d <= 4'd0;
      troco_pendente_u <= 4'd0;
    end else begin
      troco_pendente_c <= 4'(troco_pendente / 8'd100);
      troco_pendente_d <= 4'((troco_pendente / 8'd10) % 8'd10);
      troco_pendente_u <= 4'(troco_pendente % 8'd10);
    end
  end
`endif

endmodule

// File: tb/tb_troco_dispenser.sv
// Bench for troco_dispenser: directed cases plus random wallets
// against a greedy change model.
module tb_troco_dispenser;

  localparam int GAPC = 2;
  localparam int PER  = 2 + GAPC;

  int unsigned den [4] = '{5, 10, 25, 50};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        troco_valido = 1'b0;
  logic [7:0]  valor_troco = 8'd0;
  logic [23:0] moedas_carteira = 24'd0;
  logic        moeda_ejetada;
  logic [1:0]  tipo_moeda;
  logic        ocupado;
  logic        concluido;
  logic        erro;
  logic [7:0]  troco_pendente;
  logic [23:0] moedas_restantes;
`ifdef TROCO_BCD_EN
  logic [3:0]  bcd_c, bcd_d, bcd_u;
`endif

  troco_dispenser #(
    .D0(5), .D1(10), .D2(25), .D3(50), .EJECT_GAP(GAPC)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .troco_valido     (troco_valido),
    .valor_troco      (valor_troco),
    .moedas_carteira  (moedas_carteira),
    .moeda_ejetada    (moeda_ejetada),
    .tipo_moeda       (tipo_moeda),
    .ocupado          (ocupado),
    .concluido        (concluido),
    .erro             (erro),
    .troco_pendente   (troco_pendente),
    .moedas_restantes (moedas_restantes)
`ifdef TROCO_BCD_EN
    ,
    .troco_pendente_c (bcd_c),
    .troco_pendente_d (bcd_d),
    .troco_pendente_u (bcd_u)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_k [$];
  int exp_p [$];
  int exp_err;
  int exp_pend;
  logic [23:0] exp_rest;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] digits(input int p);
    return {4'(p / 100), 4'((p / 10) % 10), 4'(p % 10)};
  endfunction

  // Greedy payout: repeatedly take the largest available coin that fits
  task automatic model(input int v, input logic [23:0] w);
    int cnt [4];
    int p;
    int best;
    p = v;
    for (int k = 0; k < 4; k++) cnt[k] = int'((w >> (6 * k)) & 24'h3f);
    exp_k.delete();
    exp_p.delete();
    exp_err = 0;
    while (p != 0) begin
      best = -1;
      for (int k = 0; k < 4; k++)
        if (cnt[k] > 0 && den[k] <= p) best = k;
      if (best < 0) begin
        exp_err = 1;
        break;
      end
      exp_k.push_back(best);
      exp_p.push_back(p);
      cnt[best]--;
      p -= den[best];
    end
    exp_pend = p;
    exp_rest = 24'd0;
    for (int k = 0; k < 4; k++)
      exp_rest = exp_rest | (24'(cnt[k]) << (6 * k));
  endtask

  task automatic check_zero(input string nm);
    check({nm, ":moeda"}, 32'(moeda_ejetada), 0);
    check({nm, ":ocup"}, 32'(ocupado), 0);
    check({nm, ":concl"}, 32'(concluido), 0);
    check({nm, ":erro"}, 32'(erro), 0);
    check({nm, ":pend"}, 32'(troco_pendente), 0);
    check({nm, ":rest"}, 32'(moedas_restantes), 0);
`ifdef TROCO_BCD_EN
    check({nm, ":bcd"}, 32'({bcd_c, bcd_d, bcd_u}), 0);
`endif
  endtask

  task automatic run(input logic [7:0] v, input logic [23:0] w,
                     input string nm);
    int ci;
    int done_at;
    int n;
    ci = 0;
    done_at = -1;
    model(int'(v), w);
    n = exp_k.size();
    @(negedge clock);
    troco_valido = 1'b1;
    valor_troco = v;
    moedas_carteira = w;
    @(posedge clock);
    #1;
    troco_valido = 1'b0;
    valor_troco = 8'($urandom);
    moedas_carteira = 24'($urandom);
    check({nm, ":busy"}, 32'(ocupado), 1);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      troco_valido = (cyc == 2);
      @(posedge clock);
      #1;
      if (moeda_ejetada) begin
        if (ci < n) begin
          check({nm, ":tipo"}, 32'(tipo_moeda), 32'(exp_k[ci]));
          check({nm, ":when"}, 32'(cyc), 32'(1 + ci * PER));
`ifdef TROCO_BCD_EN
          check({nm, ":bcd_ej"}, 32'({bcd_c, bcd_d, bcd_u}),
                32'(digits(exp_p[ci])));
`endif
        end else begin
          check({nm, ":extra"}, 32'(ci + 1), 32'(n));
        end
        ci++;
      end
      if (concluido) begin
        done_at = cyc;
        break;
      end
    end
    troco_valido = 1'b0;
    check({nm, ":done_at"}, 32'(done_at), 32'(1 + n * PER));
    check({nm, ":ncoins"}, 32'(ci), 32'(n));
    check({nm, ":erro"}, 32'(erro), 32'(exp_err));
    check({nm, ":pend"}, 32'(troco_pendente), 32'(exp_pend));
    check({nm, ":rest"}, 32'(moedas_restantes), 32'(exp_rest));
    check({nm, ":ocup0"}, 32'(ocupado), 0);
`ifdef TROCO_BCD_EN
    check({nm, ":bcd"}, 32'({bcd_c, bcd_d, bcd_u}),
          32'(digits(exp_pend)));
`endif
    @(posedge clock);
    #1;
    check({nm, ":pulse"}, 32'({concluido, moeda_ejetada}), 0);
    check({nm, ":hold"}, 32'(troco_pendente), 32'(exp_pend));
  endtask

  function automatic logic [23:0] pack(input int s3, input int s2,
                                       input int s1, input int s0);
    return {6'(s3), 6'(s2), 6'(s1), 6'(s0)};
  endfunction

  initial begin
    int quiet;
    int seen;
    logic [23:0] w;

    // Reset held: strobes must be ignored and outputs stay zero
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      troco_valido = ~troco_valido;
      valor_troco = 8'($urandom);
      moedas_carteira = 24'($urandom);
      @(posedge clock);
      #1;
      check_zero("reset");
    end
    @(negedge clock);
    troco_valido = 1'b0;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_zero("released");

    run(8'd85, pack(2, 1, 3, 1), "pay85");
    check("pay85:rest_lit", 32'(moedas_restantes), 32'(pack(1, 0, 2, 1)));
    run(8'd15, pack(0, 0, 0, 1), "short15");
    check("short15:pend_lit", 32'(troco_pendente), 10);
    run(8'd0, pack(3, 2, 1, 4), "zero");
    check("zero:rest_lit", 32'(moedas_restantes), 32'(pack(3, 2, 1, 4)));
    run(8'd30, pack(0, 1, 3, 0), "greedy30");
    check("greedy30:pend_lit", 32'(troco_pendente), 5);
    run(8'd255, pack(63, 63, 63, 63), "max");
    run(8'd40, pack(0, 0, 0, 0), "empty");

    for (int t = 0; t < 20; t++) begin
      w = pack(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      run(8'($urandom_range(0, 255)), w, $sformatf("rnd%0d", t));
    end

    // Reset pulsed in the middle of an eject
    @(negedge clock);
    troco_valido = 1'b1;
    valor_troco = 8'd250;
    moedas_carteira = pack(5, 0, 0, 0);
    @(posedge clock);
    #1;
    troco_valido = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(posedge clock);
      #1;
      if (moeda_ejetada) seen = 1;
    end
    check("midrst:saw_eject", 32'(seen), 1);
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (moeda_ejetada || ocupado || concluido) quiet++;
    end
    check("midrst:quiet", 32'(quiet), 0);

    run(8'd65, pack(1, 0, 1, 1), "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
